// File: rtl/snn_batch_runner.sv
`default_nettype none
// ============================================================================
//  Module   : snn_batch_runner
//  Purpose  : Batch self-check engine for snn_core. Loads each stored image into
//             the core's input RAM, runs the core and scores the result against
//             the stored label. SNN_BATCH_STOP_ON_FAIL_EN ends a batch at the
//             first failing sample.
//  Revision : 1.0  initial release
// ============================================================================
module snn_batch_runner #(
  parameter int NUM_SAMPLES = 16,
  parameter int IMG_PIXELS  = 784,
  parameter int IMG_ADDR_W  = 10,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT_CYC = 65535,
  localparam int IDX_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        abort,
  output logic [IDX_W+IMG_ADDR_W-1:0] smp_addr,
  input  logic                        smp_q,
  output logic [IDX_W-1:0]            lbl_addr,
  input  logic [DIGIT_W-1:0]          lbl_q,
  output logic                        ram_own,
  output logic                        in_we,
  output logic [IMG_ADDR_W-1:0]       in_addr,
  output logic                        in_data,
  output logic                        core_start,
  input  logic                        core_done,
  input  logic [DIGIT_W-1:0]          core_digit,
  output logic                        busy,
  output logic                        batch_done,
  output logic [CNT_W-1:0]            pass_cnt,
  output logic [CNT_W-1:0]            fail_cnt,
  output logic                        timeout_seen,
  output logic [DIGIT_W-1:0]          last_digit
);

  localparam int PIX_W = IMG_ADDR_W + 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

`ifdef SNN_BATCH_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LABEL  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_CMP    = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               lbl_ph_q, lbl_ph_d;
  logic [DIGIT_W-1:0] label_q, label_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               done_prev_q, done_prev_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic               tmo_seen_q, tmo_seen_d;
  logic [DIGIT_W-1:0] last_digit_q, last_digit_d;
  logic               done_rise;
  logic               sample_end;
  logic               sample_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pix_q        <= '0;
      lbl_ph_q     <= 1'b0;
      label_q      <= '0;
      tmo_q        <= '0;
      done_prev_q  <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      tmo_seen_q   <= 1'b0;
      last_digit_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pix_q        <= pix_d;
      lbl_ph_q     <= lbl_ph_d;
      label_q      <= label_d;
      tmo_q        <= tmo_d;
      done_prev_q  <= done_prev_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      tmo_seen_q   <= tmo_seen_d;
      last_digit_q <= last_digit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pix_d        = pix_q;
    lbl_ph_d     = lbl_ph_q;
    label_d      = label_q;
    tmo_d        = tmo_q;
    done_prev_d  = core_done;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    tmo_seen_d   = tmo_seen_q;
    last_digit_d = last_digit_q;
    // A done level already high through START shows no rising edge in WAIT.
    done_rise    = core_done & ~done_prev_q;
    sample_end   = 1'b0;
    sample_fail  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run && !abort) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          pix_d      = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          tmo_seen_d = 1'b0;
        end
      end
      S_LOAD: begin
        pix_d = pix_q + PIX_W'(1);
        if (pix_q == PIX_W'(IMG_PIXELS)) begin
          state_d  = S_LABEL;
          lbl_ph_d = 1'b0;
        end
      end
      S_LABEL: begin
        lbl_ph_d = 1'b1;
        if (lbl_ph_q) begin
          label_d = lbl_q;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          last_digit_d = core_digit;
          state_d      = S_CMP;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          fail_cnt_d  = fail_cnt_q + CNT_W'(1);
          tmo_seen_d  = 1'b1;
          sample_end  = 1'b1;
          sample_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CMP: begin
        sample_end = 1'b1;
        if (last_digit_q == label_q) begin
          pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else begin
          fail_cnt_d  = fail_cnt_q + CNT_W'(1);
          sample_fail = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (sample_end) begin
      if ((idx_q == IDX_W'(NUM_SAMPLES - 1)) || (STOP_ON_FAIL && sample_fail)) begin
        state_d = S_FINISH;
      end else begin
        state_d = S_LOAD;
        idx_d   = idx_q + IDX_W'(1);
        pix_d   = '0;
      end
    end

    if (abort) begin
      state_d      = S_IDLE;
      pass_cnt_d   = pass_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      tmo_seen_d   = tmo_seen_q;
      last_digit_d = last_digit_q;
    end
  end

  always_comb begin
    busy       = 1'b0;
    batch_done = 1'b0;
    ram_own    = 1'b0;
    in_we      = 1'b0;
    in_addr    = '0;
    in_data    = 1'b0;
    smp_addr   = '0;
    lbl_addr   = '0;
    core_start = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy     = 1'b1;
        ram_own  = ~abort;
        smp_addr = {idx_q, pix_q[IMG_ADDR_W-1:0]};
        // Store read latency: pixel issued last cycle is written this cycle.
        if (pix_q != '0) begin
          in_we   = ~abort;
          in_addr = pix_q[IMG_ADDR_W-1:0] - IMG_ADDR_W'(1);
          in_data = smp_q;
        end
      end
      S_LABEL: begin
        busy     = 1'b1;
        lbl_addr = idx_q;
      end
      S_START: begin
        busy       = 1'b1;
        core_start = ~abort;
      end
      S_WAIT, S_CMP: busy = 1'b1;
      S_FINISH:      batch_done = ~abort;
      default: ;
    endcase
  end

  assign pass_cnt     = pass_cnt_q;
  assign fail_cnt     = fail_cnt_q;
  assign timeout_seen = tmo_seen_q;
  assign last_digit   = last_digit_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_batch_runner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_batch_runner
//  Purpose  : Self-checking bench for snn_batch_runner with sample/label store
//             models, a behavioural core model and a batch-level scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snn_batch_runner;
  localparam int NS  = 2;
  localparam int PIX = 784;
  localparam int AW  = 10;
  localparam int DW  = 4;
  localparam int TMO = 100;
  localparam int IW  = 1;
  localparam int CW  = 2;
`ifdef SNN_BATCH_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, run, abort;
  logic [IW+AW-1:0] smp_addr;
  logic smp_q;
  logic [IW-1:0] lbl_addr;
  logic [DW-1:0] lbl_q;
  logic ram_own, in_we, in_data, core_start, core_done, busy, batch_done, timeout_seen;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] core_digit, last_digit;
  logic [CW-1:0] pass_cnt, fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic          smp_mem  [NS*1024];
  logic [DW-1:0] lbl_mem  [NS];
  logic [DW-1:0] resp_dig [NS];
  int            resp_lat [NS];
  logic [DW-1:0] model_last = '0;

  snn_batch_runner #(
    .NUM_SAMPLES(NS), .IMG_PIXELS(PIX), .IMG_ADDR_W(AW), .DIGIT_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .abort(abort),
    .smp_addr(smp_addr), .smp_q(smp_q), .lbl_addr(lbl_addr), .lbl_q(lbl_q),
    .ram_own(ram_own), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .busy(busy), .batch_done(batch_done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .timeout_seen(timeout_seen), .last_digit(last_digit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    smp_q <= smp_mem[smp_addr];
    lbl_q <= lbl_mem[lbl_addr];
  end

  // Core model: done drops after start, rises resp_lat cycles later (0 = never).
  int core_k = 0;
  initial begin : core_model
    int cnt;
    int cur;
    bit drop;
    core_done = 1'b0; core_digit = '0; cnt = 0; cur = 0; drop = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        core_done = 1'b0; cnt = 0; drop = 1'b0;
      end else begin
        if (drop) begin core_done = 1'b0; drop = 1'b0; end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin core_done = 1'b1; core_digit = resp_dig[cur]; end
        end
        if (core_start) begin
          cur = core_k; core_k++;
          cnt = (cur < NS) ? resp_lat[cur] : 0;
          drop = 1'b1;
        end
      end
    end
  end

  int n_we, we_bad, ld_idx, exp_addr, n_start, start_bad, n_bdone, cyc, start_cyc;
  int load_sz[$];
  int dwell[$];
  bit prev_own, prev_start;
  initial begin : monitor
    n_we = 0; we_bad = 0; ld_idx = 0; exp_addr = 0; n_start = 0; start_bad = 0;
    n_bdone = 0; cyc = 0; start_cyc = -1; prev_own = 1'b0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (in_we === 1'b1) begin
        n_we++;
        if (!ram_own || int'(in_addr) != exp_addr || ld_idx >= NS ||
            in_data !== smp_mem[ld_idx*1024 + int'(in_addr)]) we_bad++;
        exp_addr++;
      end
      if (prev_own && !ram_own) begin load_sz.push_back(exp_addr); exp_addr = 0; ld_idx++; end
      if (core_start === 1'b1) begin n_start++; if (prev_start) start_bad++; start_cyc = cyc; end
      if (start_cyc >= 0 && ((ram_own && !prev_own) || batch_done)) begin
        dwell.push_back(cyc - start_cyc); start_cyc = -1;
      end
      if (batch_done === 1'b1) n_bdone++;
      prev_own = ram_own; prev_start = core_start;
    end
  end

  task automatic clear_mon();
    n_we = 0; we_bad = 0; ld_idx = 0; exp_addr = 0; n_start = 0; start_bad = 0;
    n_bdone = 0; start_cyc = -1;
    load_sz.delete(); dwell.delete();
  endtask

  task automatic fill_images();
    for (int i = 0; i < NS*1024; i++) smp_mem[i] = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard derives the whole batch outcome from labels and core responses.
  task automatic run_and_check(input string tag, input int extra_run_at);
    int exp_pass, exp_fail, exp_n, waited;
    bit exp_to;
    int exp_dw[$];
    exp_pass = 0; exp_fail = 0; exp_n = 0; exp_to = 1'b0;
    for (int k = 0; k < NS; k++) begin
      bit bad;
      exp_n++;
      if (resp_lat[k] == 0) begin
        bad = 1'b1; exp_to = 1'b1; exp_dw.push_back(TMO + 1);
      end else begin
        model_last = resp_dig[k];
        bad = (resp_dig[k] != lbl_mem[k]);
        exp_dw.push_back(resp_lat[k] + 2);
      end
      if (bad) exp_fail++; else exp_pass++;
      if (bad && STOP) break;
    end

    clear_mon(); core_k = 0;
    run = 1'b1; @(posedge clk); #1 run = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_run: got %b want 1", tag, busy); end
    waited = 0;
    while (batch_done !== 1'b1 && waited < 20000) begin
      @(negedge clk); waited++;
      if (waited == extra_run_at) run = 1'b1; else run = 1'b0;
    end
    run = 1'b0;
    n_cmp++;
    if (batch_done !== 1'b1) begin n_bad++; $display("FAIL %s batch_done_timeout: got %b want 1", tag, batch_done); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy); end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (pass_cnt !== CW'(exp_pass)) begin n_bad++; $display("FAIL %s pass_cnt: got %0d want %0d", tag, pass_cnt, exp_pass); end
    n_cmp++;
    if (fail_cnt !== CW'(exp_fail)) begin n_bad++; $display("FAIL %s fail_cnt: got %0d want %0d", tag, fail_cnt, exp_fail); end
    n_cmp++;
    if (timeout_seen !== exp_to) begin n_bad++; $display("FAIL %s timeout_seen: got %b want %b", tag, timeout_seen, exp_to); end
    n_cmp++;
    if (last_digit !== model_last) begin n_bad++; $display("FAIL %s last_digit: got %0d want %0d", tag, last_digit, model_last); end
    n_cmp++;
    if (n_bdone != 1) begin n_bad++; $display("FAIL %s batch_done_pulses: got %0d want 1", tag, n_bdone); end
    n_cmp++;
    if (n_start != exp_n) begin n_bad++; $display("FAIL %s core_starts: got %0d want %0d", tag, n_start, exp_n); end
    n_cmp++;
    if (start_bad != 0) begin n_bad++; $display("FAIL %s core_start_width: got %0d long pulses want 0", tag, start_bad); end
    n_cmp++;
    if (we_bad != 0 || n_we != exp_n*PIX) begin
      n_bad++; $display("FAIL %s ram_writes: got %0d writes %0d bad want %0d writes 0 bad", tag, n_we, we_bad, exp_n*PIX);
    end
    n_cmp++;
    if (load_sz.size() != exp_n) begin
      n_bad++; $display("FAIL %s load_count: got %0d want %0d", tag, load_sz.size(), exp_n);
    end else begin
      for (int k = 0; k < exp_n; k++) begin
        n_cmp++;
        if (load_sz[k] != PIX) begin n_bad++; $display("FAIL %s load_size[%0d]: got %0d want %0d", tag, k, load_sz[k], PIX); end
      end
    end
    n_cmp++;
    if (dwell.size() != exp_dw.size()) begin
      n_bad++; $display("FAIL %s dwell_count: got %0d want %0d", tag, dwell.size(), exp_dw.size());
    end else begin
      for (int k = 0; k < exp_dw.size(); k++) begin
        n_cmp++;
        if (dwell[k] != exp_dw[k]) begin n_bad++; $display("FAIL %s dwell[%0d]: got %0d want %0d", tag, k, dwell[k], exp_dw[k]); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({smp_addr, lbl_addr, ram_own, in_we, in_addr, in_data, core_start, busy, batch_done,
         pass_cnt, fail_cnt, timeout_seen, last_digit} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got busy=%b pass=%0d fail=%0d last=%0d want all 0",
                        busy, pass_cnt, fail_cnt, last_digit);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    fill_images();
    lbl_mem[0] = 4'd8; lbl_mem[1] = 4'd3;
    resp_dig[0] = 4'd8; resp_dig[1] = 4'd3; resp_lat[0] = 50; resp_lat[1] = 50;
    run_and_check("all_pass", -1);
    resp_dig[0] = 4'd5;
    run_and_check("mismatch", -1);
  endtask

  task automatic test_timeout();
    fill_images();
    resp_lat[0] = 0; resp_lat[1] = 0;
    run_and_check("timeout", -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      fill_images();
      for (int k = 0; k < NS; k++) begin
        lbl_mem[k]  = DW'($urandom_range(0, 9));
        resp_dig[k] = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 15)) : lbl_mem[k];
        resp_lat[k] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, 80);
      end
      run_and_check("random", -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NS; k++) begin
      lbl_mem[k] = DW'(k + 1); resp_dig[k] = DW'(k + 1); resp_lat[k] = $urandom_range(2, 60);
    end
    run_and_check("run_while_busy", 400);
    run_and_check("back_to_back", -1);
  endtask

  task automatic test_abort();
    fill_images();
    clear_mon(); core_k = 0;
    run = 1'b1; @(posedge clk); #1 run = 1'b0;
    repeat (300) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_we !== 1'b0 || ram_own !== 1'b0) begin
      n_bad++; $display("FAIL abort_gating: got in_we=%b ram_own=%b want 0 0", in_we, ram_own);
    end
    @(posedge clk); #1 abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (n_bdone != 0 || pass_cnt !== '0 || fail_cnt !== '0 || last_digit !== model_last) begin
      n_bad++; $display("FAIL abort_hold: got done=%0d pass=%0d fail=%0d last=%0d want 0 0 0 %0d",
                        n_bdone, pass_cnt, fail_cnt, last_digit, model_last);
    end
    run = 1'b1; abort = 1'b1;
    @(posedge clk); #1 run = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL run_abort_same_cycle: got busy=%b want 0", busy); end
    run_and_check("abort_restart", -1);
  endtask

  task automatic test_reset_mid();
    resp_lat[0] = 0; resp_lat[1] = 0;
    core_k = 0;
    run = 1'b1; @(posedge clk); #1 run = 1'b0;
    repeat (820) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({smp_addr, lbl_addr, ram_own, in_we, in_addr, in_data, core_start, busy, batch_done,
         pass_cnt, fail_cnt, timeout_seen, last_digit} !== '0) begin
      n_bad++; $display("FAIL reset_mid_batch: got busy=%b tmo=%b pass=%0d fail=%0d want all 0",
                        busy, timeout_seen, pass_cnt, fail_cnt);
    end
    model_last = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NS; k++) begin
      lbl_mem[k] = DW'($urandom_range(0, 9)); resp_dig[k] = lbl_mem[k]; resp_lat[k] = 30;
    end
    run_and_check("after_reset", -1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
